rv19_fetch_unit: RTL and testbench
==================================

Name: rv19_fetch_unit

Overview:
- Instruction-fetch front end for the 19-bit five-stage core; sits directly upstream of the decode stage.
- Owns the PC, issues reads to the 32x19 instruction memory over a valid/ready-style request/response interface, and buffers fetched words in a small prefetch queue.
- Presents {IR, NPC} pairs to decode with a valid/ready handshake.
- Accepts branch redirects from execute and squashes wrong-path words, including responses already in flight.

Parameters:
- INSTR_W, 19, instruction and PC width.
- ADDR_W, 5, instruction-memory address width; imem_addr = pc[ADDR_W-1:0].
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- RN  in  1  synchronous active-high reset.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request word address.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, 1 or more cycles after grant.
- imem_rdata  in  INSTR_W  response instruction word.
- br_en  in  1  redirect strobe from execute.
- br_target  in  INSTR_W  redirect PC.
- if_valid  out  1  queue head valid.
- if_ir  out  INSTR_W  head instruction.
- if_npc  out  INSTR_W  head fetch PC + 1.
- id_ready  in  1  decode consumes the head this cycle.

Behaviour:
- Reset (RN=1 at a clock edge): pc=RESET_PC, queue empty, outstanding=0, epoch=0, state=IDLE. Outputs while in reset: imem_req=0, if_valid=0, if_ir=0, if_npc=0. Reset overrides all other inputs, including mid-transaction; a response arriving in the first cycle after reset is dropped.
- FSM states:
  - IDLE: one cycle after reset deassertion; go to ISSUE.
  - ISSUE: imem_req=1, imem_addr=pc[ADDR_W-1:0], asserted only when queue_count + outstanding < DEPTH. On imem_gnt, record the tag {epoch, pc}, set pc=pc+1 (modulo 2^INSTR_W), go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: if tag epoch == epoch, push {imem_rdata, tag_pc+1}; otherwise discard. Go to ISSUE in the same cycle.
- At most one request is outstanding. Sustained throughput is one word per two cycles.
- imem_req and imem_addr hold stable until granted, except when a redirect occurs.
- Queue: circular buffer with log2(DEPTH)+1-bit pointers. Full when count == DEPTH; empty when count == 0. Push and pop in the same cycle are legal when not empty (count unchanged). A push when full cannot happen, because of the issue gating.
- Output: if_ir and if_npc reflect the queue head combinationally; if_valid = !empty. Pop when if_valid & id_ready. Data is held stable while if_valid=1 and id_ready=0.
- Redirect (br_en=1), taking effect at the same edge:
  - pc = br_target.
  - Queue flushed (count=0).
  - epoch toggled.
  - In WAIT: stay in WAIT; the pending response is dropped on arrival by epoch mismatch.
  - In ISSUE: a coincident grant is still counted as outstanding (tagged with the old epoch), and the next request uses br_target.
  - If br_en coincides with a pop or push, the flush wins.
  - From the next cycle, if_valid=0 until the first new-epoch word arrives.
- Minimum redirect-to-if_valid latency is 3 cycles with zero-wait memory: issue, response, valid.
- NPC arithmetic: unsigned, INSTR_W wide. PC 2^19-1 increments to 0. The imem_addr slice wraps naturally at 2^ADDR_W.

Optional Feature:
- Macro RV19_IF_PERF_EN.
- When defined:
  - Adds output stall_cnt (16 bits): counts cycles with if_valid=0 && !RN. Saturates at 16'hFFFF.
  - Adds output flush_cnt (8 bits): counts br_en pulses. Saturates at 8'hFF.
  - Both counters are cleared by RN.
- When undefined: neither port exists, no counter logic is generated, and all other behaviour is identical.

Test Plan:
- Reset then stream, with a zero-wait memory preloaded MEM[0..9]=19'h12345..19'h1234E and id_ready=1 → decode receives if_ir 12345, 12346, ... with if_npc 1, 2, ..., one word every 2 cycles; first if_valid on cycle 3 after reset release.
- Backpressure: id_ready=0 for 20 cycles → exactly DEPTH=4 words queued, imem_req=0 thereafter, if_ir held at 12345. Release → 12345..12348 are popped on consecutive cycles, then fetch resumes at pc=4.
- Redirect in WAIT: br_en with br_target=25 while the response for pc=3 is in flight (memory latency 3) → stale word 12348 is dropped; next delivered pair is if_ir=1234F, if_npc=26; no word from pc 3 or 4 appears.
- Redirect coinciding with pop, with a full queue and id_ready=1 → queue empty next cycle, if_valid=0, no duplicate or lost new-path word.
- Wrap: RESET_PC=19'h7FFFF → first if_npc=0, imem_addr=5'h1F, then 5'h00.
- Reset mid-WAIT, with RN asserted while a response is pending → imem_req=0, if_valid=0; the response arriving next cycle is ignored. With RV19_IF_PERF_EN defined: stall_cnt=0 after reset, and flush_cnt=3 after three br_en pulses.

Source files
------------

// File: rtl/rv19_fetch_unit.sv
// -----------------------------------------------------------------------------
// rv19_fetch_unit
//
// Instruction-fetch front end for the 19-bit five-stage core. Owns the PC,
// issues one request at a time to the 32x19 instruction memory, buffers the
// returned words in a small prefetch queue and hands {IR, NPC} pairs to decode
// over a valid/ready handshake. Branch redirects from execute flush the queue
// and bump an epoch bit so that a response already in flight is dropped when
// it lands.
//
// Optional feature: define RV19_IF_PERF_EN to add the stall_cnt/flush_cnt
// performance counters. With the macro undefined neither port exists.
//
// Ports
//   clk          in   core clock, rising edge
//   RN           in   synchronous active-high reset
//   imem_req     out  request valid
//   imem_addr    out  request word address (pc[ADDR_W-1:0])
//   imem_gnt     in   memory accepts the request this cycle
//   imem_rvalid  in   response valid (in order, >=1 cycle after grant)
//   imem_rdata   in   response instruction word
//   br_en        in   redirect strobe from execute
//   br_target    in   redirect PC
//   if_valid     out  queue head valid
//   if_ir        out  head instruction
//   if_npc       out  head fetch PC + 1
//   id_ready     in   decode consumes the head this cycle
//   stall_cnt    out  (RV19_IF_PERF_EN) cycles with no valid head, saturating
//   flush_cnt    out  (RV19_IF_PERF_EN) redirect pulses, saturating
// -----------------------------------------------------------------------------
module rv19_fetch_unit #(
  parameter int                 INSTR_W  = 19,
  parameter int                 ADDR_W   = 5,
  parameter int                 DEPTH    = 4,
  parameter logic [INSTR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               RN,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_en,
  input  logic [INSTR_W-1:0] br_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_ir,
  output logic [INSTR_W-1:0] if_npc,
  input  logic               id_ready
`ifdef RV19_IF_PERF_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [7:0]         flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [INSTR_W-1:0] r_pc;
  logic               r_epoch;
  logic               r_tag_epoch;
  logic [INSTR_W-1:0] r_tag_pc;

  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [INSTR_W-1:0] r_ir_mem  [DEPTH];
  logic [INSTR_W-1:0] r_npc_mem [DEPTH];

  logic [PTR_W-1:0]   w_count;
  logic               w_empty;
  logic               w_outstanding;
  logic               w_space;
  logic               w_req;
  logic               w_grant;
  logic               w_rsp;
  logic               w_push;
  logic               w_pop;
  logic               w_head_vld;

  // Queue occupancy from the extra pointer bit: wptr-rptr is exact even when
  // the index bits are equal.
  assign w_count       = r_wptr - r_rptr;
  assign w_empty       = (w_count == '0);
  assign w_outstanding = (r_state == S_WAIT);

  // Issue gating reserves a slot for the word in flight, so a push can never
  // land on a full queue.
  assign w_space = (({1'b0, w_count} + {{PTR_W{1'b0}}, w_outstanding})
                    < (PTR_W+1)'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_grant     = 1'b0;
    w_rsp       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_req = w_space;
        if (w_space && imem_gnt) begin
          w_grant     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_rsp       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A response tagged with a stale epoch belongs to a squashed path. A
  // redirect in the same cycle flushes the queue, so it also blocks the push
  // and the pop.
  assign w_push     = w_rsp && (r_tag_epoch == r_epoch) && !br_en;
  assign w_head_vld = !w_empty && !RN;
  assign w_pop      = w_head_vld && id_ready && !br_en;

  assign imem_req  = w_req && !RN;
  assign imem_addr = r_pc[ADDR_W-1:0];
  assign if_valid  = w_head_vld;
  assign if_ir     = w_head_vld ? r_ir_mem[r_rptr[IDX_W-1:0]]  : '0;
  assign if_npc    = w_head_vld ? r_npc_mem[r_rptr[IDX_W-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (RN) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_epoch <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (br_en) begin
        // Redirect overrides any PC increment from a coincident grant; that
        // grant keeps its old-epoch tag and is dropped on return.
        r_pc    <= br_target;
        r_epoch <= ~r_epoch;
        r_rptr  <= r_wptr;
      end else begin
        if (w_grant) r_pc   <= r_pc + INSTR_W'(1);
        if (w_push)  r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)   r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  // Tag and queue payload carry no reset: they are only read once a grant or
  // push has written them.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_tag_epoch <= r_epoch;
      r_tag_pc    <= r_pc;
    end
    if (w_push) begin
      r_ir_mem[r_wptr[IDX_W-1:0]]  <= imem_rdata;
      r_npc_mem[r_wptr[IDX_W-1:0]] <= r_tag_pc + INSTR_W'(1);
    end
  end

`ifdef RV19_IF_PERF_EN
  always_ff @(posedge clk) begin
    if (RN) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!w_head_vld && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (br_en && (flush_cnt != 8'hFF))          flush_cnt <= flush_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv19_fetch_unit.sv
module tb_rv19_fetch_unit;

  localparam int INSTR_W = 19;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] npc;
  } pair_t;

  logic               clk;
  logic               RN;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               br_en;
  logic [INSTR_W-1:0] br_target;
  logic               if_valid;
  logic [INSTR_W-1:0] if_ir;
  logic [INSTR_W-1:0] if_npc;
  logic               id_ready;

  // Second instance: reset PC at the top of the address space.
  logic               imem_req_w;
  logic [ADDR_W-1:0]  imem_addr_w;
  logic               imem_gnt_w;
  logic               imem_rvalid_w;
  logic [INSTR_W-1:0] imem_rdata_w;
  logic               br_en_w;
  logic [INSTR_W-1:0] br_target_w;
  logic               if_valid_w;
  logic [INSTR_W-1:0] if_ir_w;
  logic [INSTR_W-1:0] if_npc_w;
  logic               id_ready_w;

`ifdef RV19_IF_PERF_EN
  logic [15:0] stall_cnt, stall_cnt_w;
  logic [7:0]  flush_cnt, flush_cnt_w;
`endif

  logic [INSTR_W-1:0] mem [32];
  pair_t              exp_q [$];
  pair_t              mon_e;
  int                 checks   = 0;
  int                 failures = 0;
  int                 lat      = 1;
  int                 cd       = 0;
  logic [ADDR_W-1:0]  paddr    = '0;
  logic               pend_w   = 1'b0;
  logic [ADDR_W-1:0]  paddr_w  = '0;

  rv19_fetch_unit #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                    .RESET_PC(19'h00000)) dut (
    .clk(clk), .RN(RN),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_en(br_en), .br_target(br_target),
    .if_valid(if_valid), .if_ir(if_ir), .if_npc(if_npc), .id_ready(id_ready)
`ifdef RV19_IF_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  rv19_fetch_unit #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                    .RESET_PC(19'h7FFFF)) dut_wrap (
    .clk(clk), .RN(RN),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_gnt(imem_gnt_w),
    .imem_rvalid(imem_rvalid_w), .imem_rdata(imem_rdata_w),
    .br_en(br_en_w), .br_target(br_target_w),
    .if_valid(if_valid_w), .if_ir(if_ir_w), .if_npc(if_npc_w), .id_ready(id_ready_w)
`ifdef RV19_IF_PERF_EN
    , .stall_cnt(stall_cnt_w), .flush_cnt(flush_cnt_w)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Main memory: always grants, returns the word 'lat' cycles after grant.
  initial begin
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[paddr];
        end
      end
      if (imem_req && imem_gnt) begin
        cd    = lat;
        paddr = imem_addr;
      end
    end
  end

  // Wrap-instance memory: zero-wait, response in the cycle after grant.
  initial begin
    forever begin
      @(negedge clk);
      imem_rvalid_w = pend_w;
      imem_rdata_w  = mem[paddr_w];
      pend_w        = imem_req_w && imem_gnt_w;
      if (pend_w) paddr_w = imem_addr_w;
    end
  end

  // Scoreboard consumer: every handshake must match the next expected pair.
  initial begin
    forever begin
      @(negedge clk);
      if (!RN && if_valid && id_ready && !br_en) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL sb_unexpected observed ir=%0h npc=%0h expected=none", if_ir, if_npc);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checks++;
          assert ({if_ir, if_npc} === {mon_e.ir, mon_e.npc}) else begin
            failures++;
            $error("FAIL sb_pair observed ir=%0h npc=%0h expected ir=%0h npc=%0h",
                   if_ir, if_npc, mon_e.ir, mon_e.npc);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [INSTR_W-1:0] ir, input logic [INSTR_W-1:0] npc);
    pair_t p;
    p.ir  = ir;
    p.npc = npc;
    exp_q.push_back(p);
  endtask

  // Leaves the bench at cycle 0 after release (DUT in IDLE).
  task automatic do_reset(input int n);
    RN    = 1'b1;
    br_en = 1'b0;
    cyc(n);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_ir",    32'(if_ir),    32'd0);
    chk("rst_npc",   32'(if_npc),   32'd0);
`ifdef RV19_IF_PERF_EN
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
`endif
    RN = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      if (i < 10) mem[i] = 19'h12345 + 19'(i);
      else        mem[i] = 19'h50000 + 19'(i);
    end
    mem[25]     = 19'h1234F;
    RN          = 1'b1;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    br_en       = 1'b0;
    br_target   = '0;
    id_ready    = 1'b1;
    imem_gnt_w  = 1'b1;
    imem_rvalid_w = 1'b0;
    imem_rdata_w  = '0;
    br_en_w     = 1'b0;
    br_target_w = '0;
    id_ready_w  = 1'b1;

    // Stream from reset, zero-wait memory
    lat = 1;
    id_ready = 1'b1;
    do_reset(4);
    for (int i = 0; i < 6; i++) push_exp(mem[i], 19'(i + 1));
    chk("s1_c0_valid", 32'(if_valid), 32'd0);
    chk("s1_c0_req",   32'(imem_req), 32'd0);
    cyc(1);
    chk("s1_c1_req",   32'(imem_req),  32'd1);
    chk("s1_c1_addr",  32'(imem_addr), 32'd0);
    chk("wr_c1_addr",  32'(imem_addr_w), 32'h1F);
    cyc(1);
    chk("s1_c2_valid", 32'(if_valid), 32'd0);
    cyc(1);
    chk("s1_c3_valid", 32'(if_valid), 32'd1);
    chk("s1_c3_ir",    32'(if_ir),    32'h12345);
    chk("s1_c3_npc",   32'(if_npc),   32'd1);
    chk("wr_c3_valid", 32'(if_valid_w), 32'd1);
    chk("wr_c3_npc",   32'(if_npc_w),   32'd0);
    chk("wr_c3_ir",    32'(if_ir_w),    32'(mem[31]));
    chk("wr_c3_addr",  32'(imem_addr_w), 32'h00);
`ifdef RV19_IF_PERF_EN
    chk("s1_stall3", 32'(stall_cnt), 32'd3);
`endif
    cyc(1);
    chk("s1_c4_valid", 32'(if_valid), 32'd0);
    cyc(1);
    chk("s1_c5_npc",   32'(if_npc),   32'd2);
    cyc(9);
    chk("s1_drain", 32'(exp_q.size()), 32'd0);

    // Backpressure fills the queue, then drains back-to-back
    id_ready = 1'b0;
    do_reset(4);
    for (int i = 0; i < 6; i++) push_exp(mem[i], 19'(i + 1));
    cyc(7);
    chk("s2_c7_req", 32'(imem_req), 32'd1);
    cyc(2);
    chk("s2_c9_req", 32'(imem_req), 32'd0);
    cyc(11);
    chk("s2_full_req", 32'(imem_req), 32'd0);
    chk("s2_full_vld", 32'(if_valid), 32'd1);
    chk("s2_hold_ir",  32'(if_ir),    32'h12345);
    chk("s2_hold_npc", 32'(if_npc),   32'd1);
    id_ready = 1'b1;
    cyc(1);
    chk("s2_resume_req",  32'(imem_req),  32'd1);
    chk("s2_resume_addr", 32'(imem_addr), 32'd4);
    chk("s2_c21_ir",      32'(if_ir),     32'h12346);
    cyc(1);
    chk("s2_c22_ir", 32'(if_ir), 32'h12347);
    cyc(1);
    chk("s2_c23_ir", 32'(if_ir), 32'h12348);
    cyc(1);
    chk("s2_c24_ir", 32'(if_ir), 32'h12349);
    cyc(2);
    chk("s2_drain", 32'(exp_q.size()), 32'd0);

    // Redirect while the pc=3 response is in flight (latency 3)
    lat = 3;
    do_reset(4);
    for (int i = 0; i < 3; i++) push_exp(mem[i], 19'(i + 1));
    push_exp(19'h1234F, 19'd26);
    cyc(5);
    chk("s3_c5_ir", 32'(if_ir), 32'h12345);
    cyc(9);
    chk("s3_wait_req", 32'(imem_req), 32'd0);
    chk("s3_wait_vld", 32'(if_valid), 32'd0);
    br_en = 1'b1;
    br_target = 19'd25;
    cyc(1);
    br_en = 1'b0;
    chk("s3_c15_req", 32'(imem_req), 32'd0);
    chk("s3_c15_vld", 32'(if_valid), 32'd0);
    cyc(2);
    chk("s3_new_req",  32'(imem_req),  32'd1);
    chk("s3_new_addr", 32'(imem_addr), 32'd25);
    chk("s3_c17_vld",  32'(if_valid),  32'd0);
    cyc(3);
    chk("s3_c20_vld", 32'(if_valid), 32'd0);
    cyc(1);
    chk("s3_c21_ir",  32'(if_ir),  32'h1234F);
    chk("s3_c21_npc", 32'(if_npc), 32'd26);
    cyc(1);
    chk("s3_drain", 32'(exp_q.size()), 32'd0);

    // Redirect coinciding with a pop from a full queue
    lat = 1;
    id_ready = 1'b0;
    do_reset(4);
    push_exp(mem[8], 19'd9);
    push_exp(mem[9], 19'd10);
    cyc(12);
    chk("s4_full_vld", 32'(if_valid), 32'd1);
    chk("s4_full_req", 32'(imem_req), 32'd0);
    id_ready  = 1'b1;
    br_en     = 1'b1;
    br_target = 19'd8;
    cyc(1);
    br_en = 1'b0;
    chk("s4_flush_vld", 32'(if_valid),  32'd0);
    chk("s4_new_addr",  32'(imem_addr), 32'd8);
    chk("s4_new_req",   32'(imem_req),  32'd1);
    cyc(1);
    chk("s4_c14_vld", 32'(if_valid), 32'd0);
    cyc(1);
    chk("s4_c15_ir",  32'(if_ir),  32'h1234D);
    chk("s4_c15_npc", 32'(if_npc), 32'd9);
    cyc(2);
    chk("s4_c17_npc", 32'(if_npc), 32'd10);
    cyc(1);
    chk("s4_drain", 32'(exp_q.size()), 32'd0);

    // Reset while a response is pending; it lands one cycle after reset
    lat = 3;
    id_ready = 1'b1;
    do_reset(4);
    push_exp(19'h12345, 19'd1);
    cyc(3);
    RN = 1'b1;
    chk("s5_rn_req", 32'(imem_req), 32'd0);
    chk("s5_rn_vld", 32'(if_valid), 32'd0);
    cyc(1);
    RN = 1'b0;
    chk("s5_c0_vld", 32'(if_valid), 32'd0);
`ifdef RV19_IF_PERF_EN
    chk("s5_stall0", 32'(stall_cnt), 32'd0);
`endif
    cyc(1);
    chk("s5_drop_vld", 32'(if_valid),  32'd0);
    chk("s5_req",      32'(imem_req),  32'd1);
    chk("s5_addr",     32'(imem_addr), 32'd0);
    cyc(3);
    chk("s5_c8_vld", 32'(if_valid), 32'd0);
    cyc(1);
    chk("s5_c9_ir", 32'(if_ir), 32'h12345);
    cyc(1);
    chk("s5_drain", 32'(exp_q.size()), 32'd0);

    // Back-to-back redirects, one with a coincident grant, ending at 7FFFF
    lat = 1;
    id_ready = 1'b1;
    do_reset(4);
    push_exp(mem[31], 19'd0);
    push_exp(mem[0], 19'd1);
    br_en = 1'b1;
    br_target = 19'd10;
    cyc(1);
    chk("s6_c1_addr", 32'(imem_addr), 32'd10);
    br_target = 19'd20;
    cyc(1);
    br_en = 1'b0;
    cyc(1);
    chk("s6_c3_addr", 32'(imem_addr), 32'd20);
    chk("s6_c3_vld",  32'(if_valid),  32'd0);
    br_en = 1'b1;
    br_target = 19'h7FFFF;
    cyc(1);
    br_en = 1'b0;
    chk("s6_c4_vld", 32'(if_valid), 32'd0);
    cyc(1);
    chk("s6_c5_addr", 32'(imem_addr), 32'h1F);
    chk("s6_c5_vld",  32'(if_valid),  32'd0);
    cyc(1);
    chk("s6_c6_vld", 32'(if_valid), 32'd0);
    cyc(1);
    chk("s6_c7_npc",  32'(if_npc),    32'd0);
    chk("s6_c7_addr", 32'(imem_addr), 32'h00);
`ifdef RV19_IF_PERF_EN
    chk("s6_flush3", 32'(flush_cnt), 32'd3);
`endif
    cyc(2);
    chk("s6_c9_npc", 32'(if_npc), 32'd1);
    cyc(1);
    chk("s6_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
